// File: rtl/master_ds_if.sv
// master_ds_if: command/response port and shared-bus pins of master_ds.
interface master_ds_if #(parameter int BUS_WIDTH = 8);
  logic                 req_valid, req_ready, req_write;
  logic [BUS_WIDTH-1:0] req_addr, req_wdata;
  logic                 rsp_valid, rsp_parity_err, rsp_timeout;
  logic [BUS_WIDTH-1:0] rsp_rdata;
  logic [BUS_WIDTH-1:0] address, data_out, data_in;
  logic                 RB, WB, data_oe, PARITY_out, PARITY_in, ACK;
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, data_in, PARITY_in, ACK,
    output req_ready, rsp_valid, rsp_rdata, rsp_parity_err, rsp_timeout,
           address, RB, WB, data_out, data_oe, PARITY_out
  );
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, data_in, PARITY_in, ACK,
    input  req_ready, rsp_valid, rsp_rdata, rsp_parity_err, rsp_timeout,
           address, RB, WB, data_out, data_oe, PARITY_out
  );
endinterface

// File: rtl/master_ds.sv
// master_ds: single-beat bus initiator turning valid/ready commands into RB/WB/ACK strobe cycles.
module master_ds #(
  parameter int BUS_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic        clk,
  input logic        reset,
  master_ds_if.master bus
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, RELEASE, RESP} state_t;
  localparam logic [7:0] TO = 8'(TIMEOUT_CYCLES);
  state_t state, state_n;
  logic write, write_n;
  logic [7:0] cnt, cnt_n, cnt_inc;
  logic [BUS_WIDTH-1:0] addr_n, dout_n, rdata_n;
  logic rb_n, wb_n, oe_n, par_n, rvalid_n, perr_n, tout_n, ready_n;
  always_comb begin
    state_n  = state;
    write_n  = write;
    cnt_inc  = cnt + 8'd1;
    cnt_n    = cnt;
    addr_n   = bus.address;
    dout_n   = bus.data_out;
    par_n    = bus.PARITY_out;
    oe_n     = bus.data_oe;
    rb_n     = bus.RB;
    wb_n     = bus.WB;
    rvalid_n = 1'b0;
    rdata_n  = bus.rsp_rdata;
    perr_n   = bus.rsp_parity_err;
    tout_n   = bus.rsp_timeout;
    case (state)
      IDLE: if (bus.req_valid) begin
        state_n = SETUP;
        write_n = bus.req_write;
        addr_n  = bus.req_addr;
        dout_n  = bus.req_write ? bus.req_wdata : '0;
        par_n   = bus.req_write ? ^bus.req_wdata : 1'b0;
        oe_n    = bus.req_write;
        cnt_n   = '0;
        rdata_n = '0;
        perr_n  = 1'b0;
        tout_n  = 1'b0;
      end
      SETUP: begin
        state_n = STROBE;
        rb_n    = write;
        wb_n    = !write;
      end
      STROBE: begin
        cnt_n = cnt_inc;
        if (!bus.ACK) begin
          state_n = RELEASE;
          rb_n    = 1'b1;
          wb_n    = 1'b1;
          cnt_n   = '0;
          rdata_n = write ? bus.rsp_rdata : bus.data_in;
          perr_n  = write ? 1'b0 : ((^bus.data_in) != bus.PARITY_in);
        end else if (cnt_inc == TO) begin
          state_n  = RESP;
          rb_n     = 1'b1;
          wb_n     = 1'b1;
          tout_n   = 1'b1;
          rvalid_n = 1'b1;
        end
      end
      RELEASE: begin
        cnt_n = cnt_inc;
        if (bus.ACK || cnt_inc == TO) begin
          state_n  = RESP;
          rvalid_n = 1'b1;
          tout_n   = !bus.ACK;
        end
      end
      RESP: begin
        state_n = IDLE;
        cnt_n   = '0;
        addr_n  = '0;
        dout_n  = '0;
        par_n   = 1'b0;
        oe_n    = 1'b0;
      end
      default: state_n = IDLE;
    endcase
    ready_n = (state_n == IDLE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      write              <= 1'b0;
      cnt                <= '0;
      bus.address        <= '0;
      bus.data_out       <= '0;
      bus.PARITY_out     <= 1'b0;
      bus.data_oe        <= 1'b0;
      bus.RB             <= 1'b1;
      bus.WB             <= 1'b1;
      bus.req_ready      <= 1'b1;
      bus.rsp_valid      <= 1'b0;
      bus.rsp_rdata      <= '0;
      bus.rsp_parity_err <= 1'b0;
      bus.rsp_timeout    <= 1'b0;
    end else begin
      state              <= state_n;
      write              <= write_n;
      cnt                <= cnt_n;
      bus.address        <= addr_n;
      bus.data_out       <= dout_n;
      bus.PARITY_out     <= par_n;
      bus.data_oe        <= oe_n;
      bus.RB             <= rb_n;
      bus.WB             <= wb_n;
      bus.req_ready      <= ready_n;
      bus.rsp_valid      <= rvalid_n;
      bus.rsp_rdata      <= rdata_n;
      bus.rsp_parity_err <= perr_n;
      bus.rsp_timeout    <= tout_n;
    end
  end
endmodule

// File: tb/tb_master_ds.sv
// tb_master_ds: table vectors, corner sequences and random traffic against a behavioural slave/model.
module tb_master_ds;
  localparam int W  = 8;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  master_ds_if #(.BUS_WIDTH(W)) bus ();
  master_ds #(.BUS_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic       w;
    logic [7:0] a;
    logic [7:0] wd;
    int         d;
    int         l;
    logic       f;
    int         rd, pe, to, lat, sc;
  } vec_t;
  vec_t tbl [10];
  logic [7:0] smem [256];
  logic [7:0] ref_mem [256];
  int tests = 0;
  int fails = 0;
  task automatic chk(input string n, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  // Expected outcome from the bus rules: the ACK low window starts d cycles into the strobe and lasts l cycles.
  function automatic void model(input logic w, input logic [7:0] a, input logic [7:0] wd,
                                input int d, input int l, input logic f,
                                output int rd, output int pe, output int to, output int lat, output int sc);
    logic hit;
    hit = d < TO;
    sc  = hit ? d + 1 : TO;
    to  = int'(!hit || (l - 1 >= TO));
    lat = !hit ? TO + 2 : ((l - 1 >= TO) ? d + TO + 3 : d + l + 3);
    rd  = (hit && !w) ? int'(ref_mem[a]) : 0;
    pe  = int'(hit && !w && f);
    if (hit && w) ref_mem[a] = wd;
  endfunction
  task automatic run_txn(input logic w, input logic [7:0] a, input logic [7:0] wd,
                         input int d, input int l, input logic f,
                         output int rd, output int pe, output int to, output int lat,
                         output int sc, output int bad, output int idle);
    int n;
    logic ack;
    n = -1; sc = 0; bad = 0; lat = 999; rd = 0; pe = 0; to = 0; idle = 0;
    @(negedge clk);
    if (!bus.req_ready) bad = 1;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    for (int c = 1; c < 300; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (!bus.RB && !bus.WB) bad = 1;
      if (bus.data_oe && !w) bad = 1;
      if (!bus.RB || !bus.WB) begin
        sc++;
        if (n < 0) n = 0;
        if (bus.address != a || (w && (!bus.RB || bus.data_out != wd || bus.PARITY_out != ^wd))
            || (!w && !bus.WB)) bad = 1;
      end
      if (bus.rsp_valid) begin
        lat = c;
        rd  = int'(bus.rsp_rdata);
        pe  = int'(bus.rsp_parity_err);
        to  = int'(bus.rsp_timeout);
        break;
      end
      ack = n >= 0 && n >= d && n < d + l;
      bus.ACK       = !ack;
      bus.data_in   = smem[bus.address];
      bus.PARITY_in = (^smem[bus.address]) ^ f;
      if (ack && !bus.WB) smem[bus.address] = bus.data_out;
      if (n >= 0) n++;
    end
    bus.ACK = 1'b1;
    @(negedge clk);
    idle = int'(bus.req_ready && !bus.rsp_valid && !bus.data_oe && bus.address == 8'h00 && bus.RB && bus.WB);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int rd, pe, to, lat, sc, bad, idle;
    int erd, epe, eto, elat, esc;
    int acc [4];
    int rsp_c [4];
    int na, nr, rd2, cnt;
    logic w, f;
    logic [7:0] a, wd;
    int d, l;
    for (int i = 0; i < 256; i++) begin
      smem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    tbl[0] = '{1'b1, 8'hF0, 8'hA5,   1, 1, 1'b0, 0,     0, 0,  5,  2};
    tbl[1] = '{1'b1, 8'hF0, 8'h3C,   0, 1, 1'b0, 0,     0, 0,  4,  1};
    tbl[2] = '{1'b0, 8'hF0, 8'h00,   0, 1, 1'b0, 'h3C,  0, 0,  4,  1};
    tbl[3] = '{1'b0, 8'hF0, 8'h00,   0, 1, 1'b1, 'h3C,  1, 0,  4,  1};
    tbl[4] = '{1'b0, 8'h11, 8'h00, 255, 1, 1'b0, 0,     0, 1, 18, 16};
    tbl[5] = '{1'b1, 8'h22, 8'h7E,   2, 3, 1'b0, 0,     0, 0,  8,  3};
    tbl[6] = '{1'b0, 8'h22, 8'h00,   3, 2, 1'b0, 'h7E,  0, 0,  8,  4};
    tbl[7] = '{1'b1, 8'h33, 8'h55,  16, 1, 1'b0, 0,     0, 1, 18, 16};
    tbl[8] = '{1'b0, 8'h33, 8'h00,   0, 1, 1'b0, 0,     0, 0,  4,  1};
    tbl[9] = '{1'b0, 8'hF0, 8'h00,  15, 1, 1'b1, 'h3C,  1, 0, 19, 16};
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 8'h00; bus.req_wdata = 8'h00;
    bus.data_in = 8'h00; bus.PARITY_in = 1'b0; bus.ACK = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ready", int'(bus.req_ready), 1);
    chk("reset_strobes", int'({bus.RB, bus.WB}), 3);
    chk("reset_bus", int'({bus.data_oe, bus.PARITY_out, bus.address, bus.data_out}), 0);
    chk("reset_rsp", int'({bus.rsp_valid, bus.rsp_parity_err, bus.rsp_timeout, bus.rsp_rdata}), 0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      model(tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].d, tbl[i].l, tbl[i].f, erd, epe, eto, elat, esc);
      run_txn(tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].d, tbl[i].l, tbl[i].f, rd, pe, to, lat, sc, bad, idle);
      chk($sformatf("row%0d_rdata", i), rd, tbl[i].rd);
      chk($sformatf("row%0d_perr", i), pe, tbl[i].pe);
      chk($sformatf("row%0d_timeout", i), to, tbl[i].to);
      chk($sformatf("row%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("row%0d_strobe_cycles", i), sc, tbl[i].sc);
      chk($sformatf("row%0d_bus_protocol_errs", i), bad, 0);
      chk($sformatf("row%0d_idle_after", i), idle, 1);
    end
    // Reset in the middle of a write strobe drops the command with no response.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 8'h44; bus.req_wdata = 8'h99;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_wb_low", int'(bus.WB), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_outputs", int'(bus.RB && bus.WB && !bus.data_oe && bus.address == 8'h00
                               && bus.req_ready && !bus.rsp_valid), 1);
    reset = 1'b0;
    cnt = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) cnt++;
    end
    chk("rst_mid_no_rsp", cnt, 0);
    // Back-to-back: write then read with req_valid held high throughout.
    na = 0; nr = 0; rd2 = -1;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 8'h60; bus.req_wdata = 8'h01;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clk);
      if (bus.rsp_valid && nr < 4) begin
        rsp_c[nr] = c;
        if (nr == 1) rd2 = int'(bus.rsp_rdata);
        nr++;
      end
      if (bus.req_valid && bus.req_ready && na < 4) begin
        acc[na] = c;
        na++;
      end
      if (na >= 1 && c > acc[0]) begin
        bus.req_write = 1'b0;
        bus.req_wdata = 8'hFF;
      end
      if (na >= 2 && c > acc[1]) bus.req_valid = 1'b0;
      bus.ACK       = bus.RB && bus.WB;
      bus.data_in   = smem[bus.address];
      bus.PARITY_in = ^smem[bus.address];
      if (!bus.WB) smem[bus.address] = bus.data_out;
    end
    bus.ACK = 1'b1;
    bus.req_valid = 1'b0;
    ref_mem[8'h60] = 8'h01;
    chk("b2b_accepts", na, 2);
    chk("b2b_responses", nr, 2);
    if (na == 2 && nr == 2) begin
      chk("b2b_first_rsp_latency", rsp_c[0] - acc[0], 4);
      chk("b2b_second_accept_after_rsp", acc[1] - rsp_c[0], 1);
      chk("b2b_accept_spacing", acc[1] - acc[0], 5);
    end
    chk("b2b_read_data", rd2, 1);
    // Random traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      w  = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 7));
      wd = 8'($urandom);
      d  = int'($urandom_range(0, 19));
      l  = int'($urandom_range(1, 3));
      f  = 1'($urandom_range(0, 1));
      model(w, a, wd, d, l, f, erd, epe, eto, elat, esc);
      run_txn(w, a, wd, d, l, f, rd, pe, to, lat, sc, bad, idle);
      chk($sformatf("rnd%0d_rdata", i), rd, erd);
      chk($sformatf("rnd%0d_perr", i), pe, epe);
      chk($sformatf("rnd%0d_timeout", i), to, eto);
      chk($sformatf("rnd%0d_latency", i), lat, elat);
      chk($sformatf("rnd%0d_strobe_cycles", i), sc, esc);
      chk($sformatf("rnd%0d_protocol", i), bad + (1 - idle), 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
